// File: rtl/dbus_mem_responder_if.sv
// Data-bus cmd/rsp bundle between the core (master) and a memory responder (slave).
// Handshake: a cmd beat transfers on a rising clk edge where cmd_valid && cmd_ready;
// cmd_ready never depends on cmd_valid. rsp_ready is a one-cycle valid pulse with no
// backpressure; rsp_data/rsp_error are meaningful only while rsp_ready is high.
interface dbus_mem_responder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_payload_wr;
  logic [31:0] cmd_payload_address;
  logic [31:0] cmd_payload_data;
  logic [1:0]  cmd_payload_size;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;

  modport master (
    output cmd_valid, cmd_payload_wr, cmd_payload_address, cmd_payload_data, cmd_payload_size,
    input  cmd_ready, rsp_ready, rsp_data, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_payload_wr, cmd_payload_address, cmd_payload_data, cmd_payload_size,
    output cmd_ready, rsp_ready, rsp_data, rsp_error
  );
endinterface

// File: rtl/dbus_mem_responder.sv
// Behavioural dBus slave: small word-addressed memory, immediate byte-masked writes,
// in-order read responses after a fixed latency, sticky misalignment flag.
module dbus_mem_responder #(
  parameter int AW_WORDS = 4,
  parameter int QDEPTH   = 4,
  parameter int LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       stall,
  dbus_mem_responder_if.slave        bus,
  output logic [3:0]                 pending,
  output logic                       err_sticky
);
  localparam int DEPTH = 1 << AW_WORDS;
  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  // The accept cycle itself counts as the first countdown step, so the entry is
  // stored one below LATENCY; it then pops at the end of cycle N+LATENCY and the
  // registered response appears in cycle N+1+LATENCY.
  localparam logic [2:0]    CNT_INIT = 3'(LATENCY - 1);
  localparam logic [3:0]    QDEPTH_L = 4'(QDEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(QDEPTH - 1);

  logic [31:0]          mem [DEPTH];
  logic                 qValid [QDEPTH];
  logic [2:0]           qCnt   [QDEPTH];
  logic [31:0]          qData  [QDEPTH];
  logic                 qErr   [QDEPTH];
  logic [PW-1:0]        headPtr;
  logic [PW-1:0]        tailPtr;

  logic                 accept;
  logic                 misaligned;
  logic                 doWrite;
  logic                 doRead;
  logic                 doPop;
  logic [3:0]           sizeMask;
  logic [3:0]           byteMask;
  logic [AW_WORDS-1:0]  wordIdx;
  logic [31:0]          rdWord;
  logic                 unusedAddrBits;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // pending is compared before this cycle's pop, so a full queue stays closed
  // even in the cycle its head drains.
  assign bus.cmd_ready = resetn && !stall && (pending < QDEPTH_L);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign wordIdx       = bus.cmd_payload_address[AW_WORDS+1:2];
  // Address bits above the memory window alias onto the same words.
  assign unusedAddrBits = ^bus.cmd_payload_address[31:AW_WORDS+2];
  assign rdWord        = mem[wordIdx];
  assign byteMask      = sizeMask << bus.cmd_payload_address[1:0];
  assign doWrite       = accept && bus.cmd_payload_wr && !misaligned;
  assign doRead        = accept && !bus.cmd_payload_wr;
  assign doPop         = qValid[headPtr] && (qCnt[headPtr] == 3'd0);

  // Size decode: lane mask before offset shift and the misalignment check.
  always_comb begin
    sizeMask   = 4'b1111;
    misaligned = 1'b0;
    case (bus.cmd_payload_size)
      2'd0: sizeMask = 4'b0001;
      2'd1: begin
        sizeMask   = 4'b0011;
        misaligned = bus.cmd_payload_address[0];
      end
      2'd2: begin
        sizeMask   = 4'b1111;
        misaligned = |bus.cmd_payload_address[1:0];
      end
      default: begin
        sizeMask   = 4'b1111;
        misaligned = 1'b1;
      end
    endcase
  end

  // Memory: cleared on reset, byte-masked update for aligned accepted writes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteMask[b]) mem[wordIdx][8*b +: 8] <= bus.cmd_payload_data[8*b +: 8];
      end
    end
  end

  // Read queue: age all entries, pop a ripe head, push newly accepted reads.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        qValid[i] <= 1'b0;
        qCnt[i]   <= '0;
        qData[i]  <= '0;
        qErr[i]   <= 1'b0;
      end
      headPtr <= '0;
      tailPtr <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (qValid[i] && (qCnt[i] != 3'd0)) qCnt[i] <= qCnt[i] - 3'd1;
      end
      if (doPop) begin
        qValid[headPtr] <= 1'b0;
        headPtr         <= nextPtr(headPtr);
      end
      if (doRead) begin
        qValid[tailPtr] <= 1'b1;
        qCnt[tailPtr]   <= CNT_INIT;
        qData[tailPtr]  <= misaligned ? 32'h0 : rdWord;
        qErr[tailPtr]   <= misaligned;
        tailPtr         <= nextPtr(tailPtr);
      end
      case ({doRead, doPop})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  // Response register: one-cycle pulse carrying the popped entry, zero otherwise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.rsp_ready <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      bus.rsp_ready <= doPop;
      bus.rsp_data  <= doPop ? qData[headPtr] : 32'h0;
      bus.rsp_error <= doPop && qErr[headPtr];
    end
  end

  // Sticky flag for any accepted misaligned or illegal-size access.
  always_ff @(posedge clk) begin
    if (!resetn) err_sticky <= 1'b0;
    else if (accept && misaligned) err_sticky <= 1'b1;
  end
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder: a LATENCY=1 instance for data/timing checks
// and a LATENCY=6 instance so the read queue can actually fill.
module tb_dbus_mem_responder;
  localparam int FAST_LAT = 1;
  localparam int SLOW_LAT = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        resetn;
  logic        stall;
  logic        cmdValid;
  logic        cmdWr;
  logic        useSlow;
  logic [31:0] cmdAddr;
  logic [31:0] cmdData;
  logic [1:0]  cmdSize;
  logic [3:0]  fastPending;
  logic [3:0]  slowPending;
  logic        fastSticky;
  logic        slowSticky;

  dbus_mem_responder_if fastIf ();
  dbus_mem_responder_if slowIf ();

  assign fastIf.cmd_valid           = cmdValid && !useSlow;
  assign fastIf.cmd_payload_wr      = cmdWr;
  assign fastIf.cmd_payload_address = cmdAddr;
  assign fastIf.cmd_payload_data    = cmdData;
  assign fastIf.cmd_payload_size    = cmdSize;
  assign slowIf.cmd_valid           = cmdValid && useSlow;
  assign slowIf.cmd_payload_wr      = cmdWr;
  assign slowIf.cmd_payload_address = cmdAddr;
  assign slowIf.cmd_payload_data    = cmdData;
  assign slowIf.cmd_payload_size    = cmdSize;

  dbus_mem_responder #(.AW_WORDS(4), .QDEPTH(4), .LATENCY(FAST_LAT)) dutFast (
    .clk(clk), .resetn(resetn), .stall(stall), .bus(fastIf),
    .pending(fastPending), .err_sticky(fastSticky)
  );

  dbus_mem_responder #(.AW_WORDS(4), .QDEPTH(4), .LATENCY(SLOW_LAT)) dutSlow (
    .clk(clk), .resetn(resetn), .stall(stall), .bus(slowIf),
    .pending(slowPending), .err_sticky(slowSticky)
  );

  // ---------------- response capture ----------------
  logic [31:0] fData[$];
  logic        fErr[$];
  int          fCyc[$];
  logic [31:0] sData[$];
  logic        sErr[$];
  int          sCyc[$];
  logic [31:0] expQ[$];

  always @(negedge clk) begin
    if (fastIf.rsp_ready === 1'b1) begin
      fData.push_back(fastIf.rsp_data); fErr.push_back(fastIf.rsp_error); fCyc.push_back(cyc);
    end
    if (slowIf.rsp_ready === 1'b1) begin
      sData.push_back(slowIf.rsp_data); sErr.push_back(slowIf.rsp_error); sCyc.push_back(cyc);
    end
  end

  // ---------------- scoreboard helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input bit slow, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s, output int accCyc);
    useSlow  = slow;
    cmdWr    = wr;
    cmdAddr  = a;
    cmdData  = d;
    cmdSize  = s;
    cmdValid = 1'b1;
    accCyc   = -1;
    for (int k = 0; k < 40 && accCyc < 0; k++) begin
      @(negedge clk);
      if ((slow ? slowIf.cmd_ready : fastIf.cmd_ready) === 1'b1) accCyc = cyc;
      @(posedge clk); #1;
    end
    cmdValid = 1'b0;
    check("accept-in-budget", 32'(accCyc >= 0), 32'd1);
  endtask

  task automatic waitRsp(input bit slow, input int n);
    for (int k = 0; k < 40; k++) begin
      if ((slow ? sData.size() : fData.size()) >= n) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic popRsp(input bit slow, output logic [31:0] d, output logic e, output int c);
    d = 32'h0; e = 1'b0; c = -1;
    if (slow) begin
      if (sData.size() > 0) begin d = sData.pop_front(); e = sErr.pop_front(); c = sCyc.pop_front(); end
    end else begin
      if (fData.size() > 0) begin d = fData.pop_front(); e = fErr.pop_front(); c = fCyc.pop_front(); end
    end
  endtask

  task automatic readExpect(input bit slow, input logic [31:0] a, input logic [1:0] s,
                            input logic [31:0] expD, input logic expE, input string tag);
    int acc;
    int c;
    logic [31:0] d;
    logic e;
    issue(slow, 1'b0, a, 32'h0, s, acc);
    waitRsp(slow, 1);
    popRsp(slow, d, e, c);
    check({tag, "-data"}, d, expD);
    check({tag, "-err"}, 32'(e), 32'(expE));
    check({tag, "-cyc"}, c, acc + 1 + (slow ? SLOW_LAT : FAST_LAT));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    int a0;
    int a3;
    int a4;
    int c;
    int c0;
    int c1;
    int c2;
    logic [31:0] d;
    logic e;

    resetn = 1'b0; stall = 1'b0; cmdValid = 1'b0; cmdWr = 1'b0; useSlow = 1'b0;
    cmdAddr = '0; cmdData = '0; cmdSize = 2'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst-rsp_ready", 32'(fastIf.rsp_ready), 32'd0);
    check("rst-rsp_data", fastIf.rsp_data, 32'h0);
    check("rst-rsp_error", 32'(fastIf.rsp_error), 32'd0);
    check("rst-pending", 32'(fastPending), 32'd0);
    check("rst-sticky", 32'(fastSticky), 32'd0);
    check("rst-cmd_ready", 32'(fastIf.cmd_ready), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("idle-cmd_ready", 32'(fastIf.cmd_ready), 32'd1);
    stall = 1'b1;
    #1;
    check("stall-cmd_ready", 32'(fastIf.cmd_ready), 32'd0);
    stall = 1'b0;
    @(posedge clk); #1;

    // Word write then read, single one-cycle response.
    issue(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 2'd2, acc);
    readExpect(1'b0, 32'h8, 2'd2, 32'hDEADBEEF, 1'b0, "word-rd");
    @(negedge clk);
    check("pulse-ready-low", 32'(fastIf.rsp_ready), 32'd0);
    check("pulse-data-zero", fastIf.rsp_data, 32'h0);
    repeat (4) begin @(posedge clk); #1; end
    check("single-response", fData.size(), 0);

    // Byte and half masked writes, aliasing, narrow read returns full word.
    issue(1'b0, 1'b1, 32'h4, 32'h11223344, 2'd2, acc);
    issue(1'b0, 1'b1, 32'h5, 32'h0000AA00, 2'd0, acc);
    readExpect(1'b0, 32'h4, 2'd2, 32'h1122AA44, 1'b0, "byte-wr");
    issue(1'b0, 1'b1, 32'hA, 32'h12340000, 2'd1, acc);
    readExpect(1'b0, 32'h48, 2'd2, 32'h1234BEEF, 1'b0, "half-wr-alias");
    readExpect(1'b0, 32'h7, 2'd0, 32'h1122AA44, 1'b0, "byte-rd");

    // Misaligned read, misaligned write, illegal size.
    check("sticky-before", 32'(fastSticky), 32'd0);
    issue(1'b0, 1'b1, 32'h0, 32'h01020304, 2'd2, acc);
    issue(1'b0, 1'b0, 32'h2, 32'h0, 2'd2, acc);
    check("sticky-next", 32'(fastSticky), 32'd1);
    waitRsp(1'b0, 1);
    popRsp(1'b0, d, e, c);
    check("misrd-data", d, 32'h0);
    check("misrd-err", 32'(e), 32'd1);
    check("misrd-cyc", c, acc + 1 + FAST_LAT);
    issue(1'b0, 1'b1, 32'h3, 32'hFFFFFFFF, 2'd1, acc);
    readExpect(1'b0, 32'h0, 2'd2, 32'h01020304, 1'b0, "miswr-nochg");
    readExpect(1'b0, 32'h0, 2'd3, 32'h0, 1'b1, "size3-rd");

    // Read data sampled at accept; later write does not leak in.
    issue(1'b0, 1'b1, 32'h10, 32'h55667788, 2'd2, acc);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, c0);
    issue(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, acc);
    check("raw-consec", acc, c0 + 1);
    waitRsp(1'b0, 1);
    popRsp(1'b0, d, e, c);
    check("war-data", d, 32'h55667788);
    check("war-cyc", c, c0 + 1 + FAST_LAT);
    readExpect(1'b0, 32'h10, 2'd2, 32'h0, 1'b0, "war-after");

    // Back-to-back reads respond on consecutive cycles in order.
    issue(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, c0);
    issue(1'b0, 1'b0, 32'h4, 32'h0, 2'd2, c1);
    issue(1'b0, 1'b0, 32'h8, 32'h0, 2'd2, c2);
    waitRsp(1'b0, 3);
    popRsp(1'b0, d, e, c);
    check("b2b0-data", d, 32'h01020304); check("b2b0-cyc", c, c0 + 2);
    popRsp(1'b0, d, e, c);
    check("b2b1-data", d, 32'h1122AA44); check("b2b1-cyc", c, c0 + 3);
    popRsp(1'b0, d, e, c);
    check("b2b2-data", d, 32'h1234BEEF); check("b2b2-cyc", c, c0 + 4);

    // Queue fill on the long-latency instance.
    issue(1'b1, 1'b1, 32'h0, 32'hA0A0A0A0, 2'd2, acc);
    issue(1'b1, 1'b1, 32'h4, 32'hB1B1B1B1, 2'd2, acc);
    issue(1'b1, 1'b1, 32'h8, 32'hC2C2C2C2, 2'd2, acc);
    issue(1'b1, 1'b1, 32'hC, 32'hD3D3D3D3, 2'd2, acc);
    expQ.push_back(32'hA0A0A0A0); expQ.push_back(32'hB1B1B1B1);
    expQ.push_back(32'hC2C2C2C2); expQ.push_back(32'hD3D3D3D3);
    expQ.push_back(32'hD3D3D3D3);
    issue(1'b1, 1'b0, 32'h0, 32'h0, 2'd2, a0);
    issue(1'b1, 1'b0, 32'h4, 32'h0, 2'd2, acc);
    issue(1'b1, 1'b0, 32'h8, 32'h0, 2'd2, acc);
    issue(1'b1, 1'b0, 32'hC, 32'h0, 2'd2, a3);
    check("fill-consec", a3, a0 + 3);
    useSlow = 1'b1; cmdWr = 1'b0; cmdAddr = 32'h4C; cmdSize = 2'd2; cmdValid = 1'b1;
    @(negedge clk);
    check("full-cmd_ready", 32'(slowIf.cmd_ready), 32'd0);
    check("full-pending", 32'(slowPending), 32'd4);
    issue(1'b1, 1'b0, 32'h4C, 32'h0, 2'd2, a4);
    check("fifth-acc-cyc", a4, a0 + SLOW_LAT + 1);
    stall = 1'b1;
    waitRsp(1'b1, 5);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      popRsp(1'b1, d, e, c);
      check($sformatf("fill%0d-data", i), d, expQ.pop_front());
      check($sformatf("fill%0d-cyc", i), c, (i < 4) ? (a0 + i + 1 + SLOW_LAT) : (a4 + 1 + SLOW_LAT));
    end
    check("drain-pending", 32'(slowPending), 32'd0);

    // Reset with two reads in flight: they must vanish.
    issue(1'b1, 1'b0, 32'h0, 32'h0, 2'd2, acc);
    issue(1'b1, 1'b0, 32'h4, 32'h0, 2'd2, acc);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("flush-pending", 32'(slowPending), 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    check("flush-no-rsp", sData.size(), 0);
    check("flush-fast-quiet", fData.size(), 0);
    check("flush-sticky", 32'(fastSticky), 32'd0);
    readExpect(1'b1, 32'h4, 2'd2, 32'h0, 1'b0, "clr-slow");
    readExpect(1'b0, 32'h8, 2'd2, 32'h0, 1'b0, "clr-fast");

    // Illegal-size write sets sticky, leaves memory, produces no response.
    issue(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 2'd3, acc);
    check("wr-sticky", 32'(slowSticky), 32'd1);
    check("wr-no-pending", 32'(slowPending), 32'd0);
    readExpect(1'b1, 32'h0, 2'd2, 32'h0, 1'b0, "illegal-wr-nochg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
